// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet receive controller.
//   - FSM state encoding (IDLE / LEN / PAYLOAD / CSUM)
//   - error codes reported on o_err_code
//   - default start-of-packet marker
//   - helper for the payload index width
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLen     = 2'd1,
    StPayload = 2'd2,
    StCsum    = 2'd3
  } pkt_state_e;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrLen     = 2'd1,
    ErrTimeout = 2'd2,
    ErrCsum    = 2'd3
  } pkt_err_e;

  localparam logic [7:0] DefaultSyncByte = 8'hA5;

  // Index width for payloads of up to max_len bytes (never below 1 bit).
  function automatic int unsigned idx_width(input int unsigned max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_packet_ctrl_if.sv
// Byte-in / payload-out bundle of the UART packet controller.
//   master : UART byte receiver + payload consumer side
//            drives i_rx_dv/i_rx_byte, observes all o_* signals
//   slave  : uart_rx_packet_ctrl
//            i_rx_dv/i_rx_byte in; o_pld_dv, o_pld_byte, o_pld_idx, o_pkt_done,
//            o_pkt_err, o_err_code, o_busy out
interface uart_rx_packet_ctrl_if #(
  parameter int unsigned MAX_LEN = 16
) ();
  import uart_pkt_pkg::*;

  localparam int unsigned IW = idx_width(MAX_LEN);

  logic          i_rx_dv;
  logic [7:0]    i_rx_byte;
  logic          o_pld_dv;
  logic [7:0]    o_pld_byte;
  logic [IW-1:0] o_pld_idx;
  logic          o_pkt_done;
  logic          o_pkt_err;
  logic [1:0]    o_err_code;
  logic          o_busy;

  modport master (
    output i_rx_dv, i_rx_byte,
    input  o_pld_dv, o_pld_byte, o_pld_idx, o_pkt_done, o_pkt_err, o_err_code, o_busy
  );

  modport slave (
    input  i_rx_dv, i_rx_byte,
    output o_pld_dv, o_pld_byte, o_pld_idx, o_pkt_done, o_pkt_err, o_err_code, o_busy
  );

endinterface

// File: rtl/uart_pkt_timeout.sv
// Inter-byte timeout for the packet controller: loadable down-counter.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   clear_i      : reload to TIMEOUT_CLKS-1 (has priority over counting)
//   enable_i     : count down one per clock while set
//   expired_o    : combinational pulse, counter at zero while enabled and not cleared
module uart_pkt_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 4340
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LoadVal = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LoadVal;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= LoadVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving on the expiry cycle clears the counter, so it wins over the timeout.
  assign expired_o = enable_i && !clear_i && (cnt_q == '0);

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Packet framer behind the UART byte receiver.
// Frames [SYNC][LEN][PAYLOAD x LEN][CSUM?], streams payload bytes with their index,
// pulses o_pkt_done / o_pkt_err per packet and aborts on inter-byte timeout.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   pkt_io       : uart_rx_packet_ctrl_if.slave (byte strobe in, payload/status out)
// Build option: define UART_PKT_CHECKSUM_EN to expect a trailing checksum byte
// (XOR of LEN and all payload bytes). Without it there is no CSUM state and
// error code 3 is never produced.
// All responses are registered and appear one clock after the causing strobe.
module uart_rx_packet_ctrl
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = DefaultSyncByte,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 4340
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  uart_rx_packet_ctrl_if.slave  pkt_io
);

  localparam int unsigned IW = idx_width(MAX_LEN);

  pkt_state_e    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          pld_dv_q, pld_dv_d;
  logic [7:0]    pld_byte_q, pld_byte_d;
  logic [IW-1:0] pld_idx_q, pld_idx_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  pkt_err_e      err_code_q, err_code_d;

  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       is_sync;
  logic       len_bad;
  logic       last_byte;
  logic       tmo_clr, tmo_en, tmo_expired;

  assign rx_dv     = pkt_io.i_rx_dv;
  assign rx_byte   = pkt_io.i_rx_byte;
  assign is_sync   = rx_dv && (rx_byte == SYNC_BYTE);
  assign len_bad   = (rx_byte == 8'd0) || (32'(rx_byte) > MAX_LEN);
  assign last_byte = ((32'(idx_q) + 32'd1) == 32'(len_q));

  // Held loaded while idle; every accepted byte restarts the inter-byte window.
  assign tmo_clr = rx_dv || (state_q == StIdle);
  assign tmo_en  = (state_q != StIdle);

  uart_pkt_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .clear_i   (tmo_clr),
    .enable_i  (tmo_en),
    .expired_o (tmo_expired)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (is_sync) state_d = StLen;
      end
      StLen: begin
        if (rx_dv) begin
          state_d = len_bad ? StIdle : StPayload;
        end else if (tmo_expired) begin
          state_d = StIdle;
        end
      end
      StPayload: begin
        if (rx_dv) begin
          if (last_byte) begin
`ifdef UART_PKT_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StIdle;
`endif
          end
        end else if (tmo_expired) begin
          state_d = StIdle;
        end
      end
`ifdef UART_PKT_CHECKSUM_EN
      StCsum: begin
        if (rx_dv || tmo_expired) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    len_d      = len_q;
    idx_d      = idx_q;
    pld_dv_d   = 1'b0;
    pld_byte_d = pld_byte_q;
    pld_idx_d  = pld_idx_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
`ifdef UART_PKT_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (is_sync) err_code_d = ErrNone;
      end
      StLen: begin
        if (rx_dv) begin
          if (len_bad) begin
            err_d      = 1'b1;
            err_code_d = ErrLen;
          end else begin
            len_d = rx_byte;
            idx_d = '0;
`ifdef UART_PKT_CHECKSUM_EN
            csum_d = rx_byte;
`endif
          end
        end else if (tmo_expired) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
        end
      end
      StPayload: begin
        if (rx_dv) begin
          pld_dv_d   = 1'b1;
          pld_byte_d = rx_byte;
          pld_idx_d  = idx_q;
`ifdef UART_PKT_CHECKSUM_EN
          csum_d = csum_q ^ rx_byte;
`endif
          if (last_byte) begin
`ifndef UART_PKT_CHECKSUM_EN
            done_d = 1'b1;
`endif
          end else begin
            // Only advance below LEN-1 so the index cannot wrap at MAX_LEN.
            idx_d = idx_q + IW'(1);
          end
        end else if (tmo_expired) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
        end
      end
`ifdef UART_PKT_CHECKSUM_EN
      StCsum: begin
        if (rx_dv) begin
          if (rx_byte == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrCsum;
          end
        end else if (tmo_expired) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len_q      <= '0;
      idx_q      <= '0;
      pld_dv_q   <= 1'b0;
      pld_byte_q <= '0;
      pld_idx_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
`ifdef UART_PKT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      len_q      <= len_d;
      idx_q      <= idx_d;
      pld_dv_q   <= pld_dv_d;
      pld_byte_q <= pld_byte_d;
      pld_idx_q  <= pld_idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef UART_PKT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign pkt_io.o_pld_dv   = pld_dv_q;
  assign pkt_io.o_pld_byte = pld_byte_q;
  assign pkt_io.o_pld_idx  = pld_idx_q;
  assign pkt_io.o_pkt_done = done_q;
  assign pkt_io.o_pkt_err  = err_q;
  assign pkt_io.o_err_code = err_code_q;
  assign pkt_io.o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Self-checking bench for uart_rx_packet_ctrl: a scoreboard queue of expected
// payload/done/error events is filled as bytes are driven and drained by a
// monitor sampling the DUT outputs on the falling clock edge.
module tb_uart_rx_packet_ctrl;
  localparam int unsigned MaxLen      = 16;
  localparam int unsigned TimeoutClks = 4340;
  localparam int          Gap         = 30;

  localparam int EvPld  = 0;
  localparam int EvDone = 1;
  localparam int EvErr  = 2;

  typedef struct {
    int         kind;
    logic [7:0] b;
    int         idx;
    int         code;
  } ev_t;

  logic i_clk = 1'b0;
  logic i_rst;

  uart_rx_packet_ctrl_if #(.MAX_LEN(MaxLen)) bus ();

  uart_rx_packet_ctrl #(
    .SYNC_BYTE    (8'hA5),
    .MAX_LEN      (MaxLen),
    .TIMEOUT_CLKS (TimeoutClks)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .pkt_io (bus)
  );

  always #20 i_clk = ~i_clk;

  int         total = 0;
  int         bad   = 0;
  ev_t        exp_q[$];
  logic [7:0] pbuf[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] b, input int idx, input int code);
    ev_t e;
    e.kind = kind;
    e.b    = b;
    e.idx  = idx;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic take_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq($sformatf("sb_underflow_kind%0d", kind), exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check_eq("evt_kind", kind, e.kind);
      if (kind == EvPld && e.kind == EvPld) begin
        check_eq("pld_byte", bus.o_pld_byte, e.b);
        check_eq("pld_idx", 32'(bus.o_pld_idx), e.idx);
      end else if (kind == EvDone && e.kind == EvDone) begin
        check_eq("done_code", bus.o_err_code, 0);
      end else if (kind == EvErr && e.kind == EvErr) begin
        check_eq("err_code", bus.o_err_code, e.code);
      end
    end
  endtask

  // Payload is handled before done so same-cycle events pop in driven order.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (bus.o_pkt_done && bus.o_pkt_err) check_eq("done_err_excl", bus.o_pkt_err, 0);
      if (bus.o_pld_dv)   take_ev(EvPld);
      if (bus.o_pkt_done) take_ev(EvDone);
      if (bus.o_pkt_err)  take_ev(EvErr);
    end
  end

  // Called at a falling edge; the strobe is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_dv   = 1'b1;
    bus.i_rx_byte = b;
    @(negedge i_clk);
    bus.i_rx_dv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Sends a well-formed packet carrying pbuf, strobes spaced gap clocks apart.
  task automatic send_good(input int gap);
    logic [7:0] len;
    logic [7:0] cs;
    len = 8'(pbuf.size());
    cs  = len;
    send_byte(8'hA5);
    check_eq("code_clr_on_sync", bus.o_err_code, 0);
    idle(gap - 1);
    send_byte(len);
    idle(gap - 1);
    for (int i = 0; i < pbuf.size(); i++) begin
      push_ev(EvPld, pbuf[i], i, 0);
      cs = cs ^ pbuf[i];
`ifndef UART_PKT_CHECKSUM_EN
      if (i == pbuf.size() - 1) push_ev(EvDone, 8'h00, 0, 0);
`endif
      send_byte(pbuf[i]);
      idle(gap - 1);
    end
`ifdef UART_PKT_CHECKSUM_EN
    push_ev(EvDone, 8'h00, 0, 0);
    send_byte(cs);
    idle(gap - 1);
`endif
  endtask

  int n;

  initial begin
    i_rst         = 1'b1;
    bus.i_rx_dv   = 1'b0;
    bus.i_rx_byte = 8'h00;
    idle(3);
    check_eq("rst_pld_dv", bus.o_pld_dv, 0);
    check_eq("rst_done", bus.o_pkt_done, 0);
    check_eq("rst_err", bus.o_pkt_err, 0);
    check_eq("rst_code", bus.o_err_code, 0);
    check_eq("rst_busy", bus.o_busy, 0);
    check_eq("rst_idx", 32'(bus.o_pld_idx), 0);
    i_rst = 1'b0;
    idle(2);

    // Basic three-byte packet at real UART byte spacing.
    pbuf = '{8'h11, 8'h22, 8'h33};
    send_good(2170);
    check_eq("t1_code", bus.o_err_code, 0);
    check_eq("t1_busy", bus.o_busy, 0);

    // Bad lengths: zero and MAX_LEN+1.
    send_byte(8'hA5);
    check_eq("t2_busy_after_sync", bus.o_busy, 1);
    idle(Gap - 1);
    push_ev(EvErr, 8'h00, 0, 1);
    send_byte(8'h00);
    check_eq("t2_busy_len0", bus.o_busy, 0);
    idle(Gap - 1);
    check_eq("t2_code_held", bus.o_err_code, 1);
    send_byte(8'hA5);
    idle(Gap - 1);
    push_ev(EvErr, 8'h00, 0, 1);
    send_byte(8'(MaxLen + 1));
    idle(Gap - 1);
    check_eq("t2_code_len17", bus.o_err_code, 1);
    pbuf = '{8'h7E};
    send_good(Gap);
    check_eq("t2_code_cleared", bus.o_err_code, 0);

    // LEN == MAX_LEN is accepted and the index reaches MAX_LEN-1.
    pbuf.delete();
    for (int i = 0; i < MaxLen; i++) pbuf.push_back(8'(i * 7 + 3));
    send_good(Gap);

    // Byte that caused a LEN error is not re-examined as SYNC; trailing bytes ignored.
    send_byte(8'hA5);
    idle(Gap - 1);
    push_ev(EvErr, 8'h00, 0, 1);
    send_byte(8'hA5);
    idle(Gap - 1);
    send_byte(8'h01);
    idle(Gap - 1);
    send_byte(8'h42);
    idle(Gap - 1);
    check_eq("t2_discard_busy", bus.o_busy, 0);

    // Timeout fires exactly TIMEOUT_CLKS after the last strobe.
    send_byte(8'hA5);
    idle(Gap - 1);
    send_byte(8'h02);
    idle(Gap - 1);
    push_ev(EvPld, 8'hAA, 0, 0);
    push_ev(EvErr, 8'h00, 0, 2);
    send_byte(8'hAA);
    n = 0;
    while (!bus.o_pkt_err && n < TimeoutClks + 200) begin
      @(negedge i_clk);
      n++;
    end
    check_eq("t3_tmo_latency", n, TimeoutClks);
    check_eq("t3_tmo_busy", bus.o_busy, 0);
    check_eq("t3_tmo_code", bus.o_err_code, 2);
    idle(Gap);

    // Strobe on the expiry cycle is accepted instead of timing out.
    send_byte(8'hA5);
    idle(Gap - 1);
    send_byte(8'h02);
    idle(Gap - 1);
    push_ev(EvPld, 8'hAA, 0, 0);
    send_byte(8'hAA);
    idle(TimeoutClks - 1);
    push_ev(EvPld, 8'hBB, 1, 0);
`ifndef UART_PKT_CHECKSUM_EN
    push_ev(EvDone, 8'h00, 0, 0);
`endif
    send_byte(8'hBB);
`ifdef UART_PKT_CHECKSUM_EN
    idle(Gap - 1);
    push_ev(EvDone, 8'h00, 0, 0);
    send_byte(8'h02 ^ 8'hAA ^ 8'hBB);
`endif
    idle(Gap);
    check_eq("t3_expiry_code", bus.o_err_code, 0);
    check_eq("t3_expiry_busy", bus.o_busy, 0);

    // SYNC value inside the payload is plain data.
    pbuf = '{8'hA5, 8'h01};
    send_good(Gap);

`ifdef UART_PKT_CHECKSUM_EN
    // Checksum mismatch: payload still streamed, then error code 3.
    send_byte(8'hA5);
    idle(Gap - 1);
    send_byte(8'h02);
    idle(Gap - 1);
    push_ev(EvPld, 8'hA5, 0, 0);
    send_byte(8'hA5);
    idle(Gap - 1);
    push_ev(EvPld, 8'h01, 1, 0);
    send_byte(8'h01);
    idle(Gap - 1);
    push_ev(EvErr, 8'h00, 0, 3);
    send_byte(8'h00);
    idle(Gap - 1);
    check_eq("t4_csum_code", bus.o_err_code, 3);
`endif

    // Leading garbage is ignored.
    send_byte(8'h00);
    idle(Gap - 1);
    send_byte(8'hFF);
    idle(Gap - 1);
    send_byte(8'h5A);
    idle(Gap - 1);
    check_eq("t5_garbage_busy", bus.o_busy, 0);
    pbuf = '{8'h42};
    send_good(Gap);

    // Asynchronous reset between clock edges in the middle of a payload.
    send_byte(8'hA5);
    idle(Gap - 1);
    send_byte(8'h03);
    idle(Gap - 1);
    push_ev(EvPld, 8'h11, 0, 0);
    send_byte(8'h11);
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("t6_rst_pld_dv", bus.o_pld_dv, 0);
    check_eq("t6_rst_pld_byte", bus.o_pld_byte, 0);
    check_eq("t6_rst_busy", bus.o_busy, 0);
    check_eq("t6_rst_done", bus.o_pkt_done, 0);
    check_eq("t6_rst_err", bus.o_pkt_err, 0);
    idle(2);
    i_rst = 1'b0;
    idle(2);
    pbuf = '{8'h5A, 8'hC3};
    send_good(Gap);

    idle(10);
    check_eq("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
